// File: rtl/prince_ti_sbox_seq.sv
// Nibble-serial sequencer feeding one shared PRINCE TI S-box with all 16 nibbles of every share.
// Optional macro PRINCE_SBOX_INV_EN adds inv/sb_inv to select the inverse S-box per operation.
module prince_ti_sbox_seq #(
    parameter int SHARES   = 3,
    parameter int SBOX_LAT = 3,
    parameter int NIBBLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [64*SHARES-1:0]  state_in,
`ifdef PRINCE_SBOX_INV_EN
    input  logic                  inv,
    output logic                  sb_inv,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [64*SHARES-1:0]  state_out,
    output logic [4*SHARES-1:0]   sb_in,
    output logic                  sb_in_valid,
    output logic                  sb_en,
    input  logic [4*SHARES-1:0]   sb_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_NIB = 4'(NIBBLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [64*SHARES-1:0]   isr;
    logic [64*SHARES-1:0]   isr_shift;
    logic [64*SHARES-1:0]   osr;
    logic [64*SHARES-1:0]   osr_next;
    logic [3:0]             issue_cnt;
    logic [3:0]             cap_cnt;
    logic [SBOX_LAT-1:0]    vdl;
    logic                   cap_live;
    logic                   accept;
    logic [SHARES-1:0]      unused_osr_lsn;

    assign cap_live = vdl[SBOX_LAT-1];
    assign accept   = (state == IDLE) && start;

    // Per-share shift paths; the nibble falling out of the output register is discarded.
    always_comb begin
        isr_shift      = '0;
        osr_next       = '0;
        unused_osr_lsn = '0;
        for (int s = 0; s < SHARES; s++) begin
            isr_shift[64*s +: 64] = {4'h0, isr[64*s+4 +: 60]};
            osr_next[64*s +: 64]  = {sb_out[4*s +: 4], osr[64*s+4 +: 60]};
            unused_osr_lsn[s]     = ^osr[64*s +: 4];
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        sb_in       = '0;
        sb_in_valid = 1'b0;
        sb_en       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = FEED;
                end
            end
            FEED: begin
                sb_en       = 1'b1;
                sb_in_valid = 1'b1;
                for (int s = 0; s < SHARES; s++) begin
                    sb_in[4*s +: 4] = isr[64*s +: 4];
                end
                if (issue_cnt == LAST_NIB) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                sb_en = 1'b1;
                if (cap_live && (cap_cnt == LAST_NIB)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The valid delay line tracks the datapath latency so captures line up with sb_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            isr       <= '0;
            osr       <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            vdl       <= '0;
            state_out <= '0;
        end else begin
            state  <= state_next;
            vdl[0] <= sb_in_valid;
            for (int i = 1; i < SBOX_LAT; i++) begin
                vdl[i] <= vdl[i-1];
            end
            if (accept) begin
                isr       <= state_in;
                issue_cnt <= '0;
            end else if (state == FEED) begin
                isr       <= isr_shift;
                issue_cnt <= issue_cnt + 4'd1;
            end
            if (accept) begin
                cap_cnt <= '0;
            end else if (cap_live) begin
                osr     <= osr_next;
                cap_cnt <= cap_cnt + 4'd1;
            end
            // The final nibble lands in the same edge, so take the shifted value.
            if ((state == DRAIN) && (state_next == DONE)) begin
                state_out <= osr_next;
            end
        end
    end

`ifdef PRINCE_SBOX_INV_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= inv;
        end
    end

    assign sb_inv = inv_q;
`endif

endmodule

// File: tb/tb_prince_ti_sbox_seq.sv
// Directed bench for prince_ti_sbox_seq at SBOX_LAT 3, 1 and 8 with identity and behavioural TI datapaths.
// Exercises the PRINCE_SBOX_INV_EN ports when that macro is defined.
module tb_prince_ti_sbox_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [191:0] state_in;
    logic         mode;
    int           checks = 0;
    int           failures = 0;
    int           cyc;

    logic         busy3, done3, v3, en3;
    logic         busy1, done1, v1, en1;
    logic         busy8, done8, v8, en8;
    logic [191:0] so3, so1, so8;
    logic [11:0]  sbi3, sbi1, sbi8;
    logic [11:0]  sbo3, sbo1, sbo8;
    logic [11:0]  p3 [3];
    logic [11:0]  p1 [1];
    logic [11:0]  p8 [8];

`ifdef PRINCE_SBOX_INV_EN
    logic inv;
    logic sbinv3, sbinv1, sbinv8;
`endif

    always #5 clk = ~clk;

    prince_ti_sbox_seq #(.SHARES(3), .SBOX_LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
`ifdef PRINCE_SBOX_INV_EN
        .inv(inv), .sb_inv(sbinv3),
`endif
        .busy(busy3), .done(done3), .state_out(so3), .sb_in(sbi3),
        .sb_in_valid(v3), .sb_en(en3), .sb_out(sbo3)
    );

    prince_ti_sbox_seq #(.SHARES(3), .SBOX_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
`ifdef PRINCE_SBOX_INV_EN
        .inv(inv), .sb_inv(sbinv1),
`endif
        .busy(busy1), .done(done1), .state_out(so1), .sb_in(sbi1),
        .sb_in_valid(v1), .sb_en(en1), .sb_out(sbo1)
    );

    prince_ti_sbox_seq #(.SHARES(3), .SBOX_LAT(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
`ifdef PRINCE_SBOX_INV_EN
        .inv(inv), .sb_inv(sbinv8),
`endif
        .busy(busy8), .done(done8), .state_out(so8), .sb_in(sbi8),
        .sb_in_valid(v8), .sb_en(en8), .sb_out(sbo8)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hB; 4'h1: sbox = 4'hF; 4'h2: sbox = 4'h3; 4'h3: sbox = 4'h2;
            4'h4: sbox = 4'hA; 4'h5: sbox = 4'hC; 4'h6: sbox = 4'h9; 4'h7: sbox = 4'h1;
            4'h8: sbox = 4'h6; 4'h9: sbox = 4'h7; 4'hA: sbox = 4'h8; 4'hB: sbox = 4'h0;
            4'hC: sbox = 4'hE; 4'hD: sbox = 4'h5; 4'hE: sbox = 4'hD; default: sbox = 4'h4;
        endcase
    endfunction

    // Shares out: S(x)^x1, x1, 0 -- their XOR is S of the unmasked nibble.
    function automatic logic [11:0] dpath(input logic [11:0] x, input logic m);
        logic [3:0] u;
        u = x[3:0] ^ x[7:4] ^ x[11:8];
        dpath = m ? {4'h0, x[7:4], sbox(u) ^ x[7:4]} : x;
    endfunction

    function automatic logic [11:0] exp_sbin(input logic [191:0] st, input int k);
        logic [11:0] r;
        for (int s = 0; s < 3; s++) begin
            r[4*s +: 4] = st[64*s + 4*k +: 4];
        end
        return r;
    endfunction

    function automatic logic [63:0] share_xor(input logic [191:0] st);
        return st[63:0] ^ st[127:64] ^ st[191:128];
    endfunction

    always @(posedge clk) begin
        if (en3) begin
            p3[0] <= sbi3;
            for (int i = 1; i < 3; i++) p3[i] <= p3[i-1];
        end
        if (en1) begin
            p1[0] <= sbi1;
        end
        if (en8) begin
            p8[0] <= sbi8;
            for (int i = 1; i < 8; i++) p8[i] <= p8[i-1];
        end
    end

    assign sbo3 = dpath(p3[2], mode);
    assign sbo1 = dpath(p1[0], mode);
    assign sbo8 = dpath(p8[7], mode);

    task automatic check_output(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_stimulus(input logic s, input logic [191:0] st);
        start    = s;
        state_in = st;
    endtask

    task automatic run_op(input logic [191:0] st, input int n);
        cyc = 0;
        apply_stimulus(1'b1, st);
        step();
        start = 1'b0;
        for (int i = 1; i < n; i++) step();
    endtask

    logic [191:0] vec1, vec2, vec3, vec4;
    logic         feed;

    initial begin
        vec1 = {64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        vec2 = {64'h0, 64'h1111111111111111, 64'h1111111111111111};
        vec3 = {64'h0123456789ABCDEF ^ 64'h0F0F0F0F0F0F0F0F ^ 64'h3333333333333333,
                64'h3333333333333333, 64'h0F0F0F0F0F0F0F0F};
        vec4 = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hDEADBEEFCAFEF00D};
        rst = 1'b1; start = 1'b0; state_in = '0; mode = 1'b0; cyc = 0;
`ifdef PRINCE_SBOX_INV_EN
        inv = 1'b0;
`endif
        @(negedge clk);
        step();
        step();
        check_output("rst_busy", busy3, 0);
        check_output("rst_done", done3, 0);
        check_output("rst_valid", v3, 0);
        check_output("rst_en", en3, 0);
        check_output("rst_sbin", sbi3, 0);
        check_output("rst_state_out", so3, 0);
        rst = 1'b0;
        step();

        $display("[TB] identity datapath, latencies 3/1/8");
        cyc = 0;
        check_output("t1_idle", busy3, 0);
        apply_stimulus(1'b1, vec1);
`ifdef PRINCE_SBOX_INV_EN
        inv = 1'b1;
`endif
        for (int c = 1; c <= 30; c++) begin
            step();
            start = 1'b0;
`ifdef PRINCE_SBOX_INV_EN
            if (c == 5) inv = 1'b0;
            if (c <= 20) check_output("inv_sb_inv", sbinv3, 1);
`endif
            feed = (c >= 1) && (c <= 16);
            check_output("t1_busy3", busy3, (c >= 1) && (c <= 20));
            check_output("t1_done3", done3, c == 20);
            check_output("t1_en3", en3, (c >= 1) && (c <= 19));
            check_output("t1_valid3", v3, feed);
            check_output("t1_sbin3", sbi3, feed ? exp_sbin(vec1, c - 1) : 12'h0);
            check_output("t1_busy1", busy1, (c >= 1) && (c <= 18));
            check_output("t1_done1", done1, c == 18);
            check_output("t1_valid1", v1, feed);
            check_output("t1_busy8", busy8, (c >= 1) && (c <= 25));
            check_output("t1_done8", done8, c == 25);
            check_output("t1_valid8", v8, feed);
            check_output("t1_sbin8", sbi8, feed ? exp_sbin(vec1, c - 1) : 12'h0);
            if (c == 20) check_output("t1_out_at_done", so3, vec1);
        end
        check_output("t1_out3", so3, vec1);
        check_output("t1_out1", so1, vec1);
        check_output("t1_out8", so8, vec1);

        $display("[TB] behavioural TI datapath");
        mode = 1'b1;
        run_op(vec2, 27);
        check_output("t2_zero_xor3", share_xor(so3), 64'hBBBBBBBBBBBBBBBB);
        check_output("t2_zero_xor8", share_xor(so8), 64'hBBBBBBBBBBBBBBBB);
        check_output("t2_share2", so3[191:128], 0);
        run_op(vec3, 27);
        check_output("t2_ramp_xor3", share_xor(so3), 64'hBF32AC916780E5D4);
        check_output("t2_ramp_xor1", share_xor(so1), 64'hBF32AC916780E5D4);
        mode = 1'b0;

        $display("[TB] start held high");
        cyc = 0;
        apply_stimulus(1'b1, vec1);
        for (int c = 0; c <= 62; c++) begin
            check_output("t3_busy", busy3, (c % 21) != 0);
            check_output("t3_done", done3, (c % 21) == 20);
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check_output("t3_out", so3, vec1);

        $display("[TB] reset mid-operation");
        run_op(vec4, 10);
        rst = 1'b1;
        step();
        check_output("t4_busy", busy3, 0);
        check_output("t4_done", done3, 0);
        check_output("t4_valid", v3, 0);
        check_output("t4_en", en3, 0);
        check_output("t4_sbin", sbi3, 0);
        check_output("t4_state_out", so3, 0);
        check_output("t4_busy8", busy8, 0);
        rst = 1'b0;
        step();
        run_op(vec4, 27);
        check_output("t4_out3", so3, vec4);
        check_output("t4_out1", so1, vec4);
        check_output("t4_out8", so8, vec4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
